// File: rtl/length_accumulator_if.sv
// Beat input, flush and block-result handshake bundle for length_accumulator.
// The master drives beats and consumes results; the slave is the accumulator.
interface length_accumulator_if;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_pat1;
  logic [2:0]  i_pat2;
  logic        i_flush;
  logic        o_blk_valid;
  logic        i_blk_ready;
  logic [11:0] o_blk_len;
  logic        o_incompressible;
  logic        o_illegal;
  logic [5:0]  o_beat_cnt;

  modport master (
    output i_valid, i_pat1, i_pat2, i_flush, i_blk_ready,
    input  o_ready, o_blk_valid, o_blk_len, o_incompressible, o_illegal, o_beat_cnt
  );

  modport slave (
    input  i_valid, i_pat1, i_pat2, i_flush, i_blk_ready,
    output o_ready, o_blk_valid, o_blk_len, o_incompressible, o_illegal, o_beat_cnt
  );
endinterface

// File: rtl/length_accumulator.sv
// Sums per-word compressed lengths of BEATS two-word beats into one block result,
// with early flush, sticky illegal-code flag and a valid/ready result handshake.
module length_accumulator #(
  parameter int BEATS       = 32,
  parameter int UNCOMP_BITS = 2048
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  length_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [11:0] acc_reg, acc_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic        illegal_reg, illegal_next;

  logic [5:0]  len_lut [8];
  logic [7:0]  illegal_lut;
  logic [11:0] beat_len;
  logic        beat_illegal;
  logic        accept;
  logic        last_beat;

  function automatic logic [5:0] code_len(input logic [2:0] code);
    case (code)
      3'd0:    code_len = 6'd2;
      3'd1:    code_len = 6'd34;
      3'd2:    code_len = 6'd6;
      3'd3:    code_len = 6'd24;
      3'd4:    code_len = 6'd12;
      3'd5:    code_len = 6'd16;
      default: code_len = 6'd34;  // illegal codes cost a full raw word
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lut
      assign len_lut[gi]     = code_len(3'(gi));
      assign illegal_lut[gi] = (gi >= 6);
    end
  endgenerate

  assign beat_len     = 12'(len_lut[bus.i_pat1]) + 12'(len_lut[bus.i_pat2]);
  assign beat_illegal = illegal_lut[bus.i_pat1] | illegal_lut[bus.i_pat2];
  assign accept       = bus.i_valid && (state_reg != DONE);
  assign last_beat    = (cnt_reg + 6'd1) == 6'(BEATS);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg   <= IDLE;
      acc_reg     <= 12'd0;
      cnt_reg     <= 6'd0;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      acc_reg     <= acc_next;
      cnt_reg     <= cnt_next;
      illegal_reg <= illegal_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    acc_next     = acc_reg;
    cnt_next     = cnt_reg;
    illegal_next = illegal_reg;
    case (state_reg)
      IDLE, ACCUM: begin
        // IDLE always holds a cleared accumulator, so one add path serves both
        if (accept) begin
          acc_next     = acc_reg + beat_len;
          cnt_next     = cnt_reg + 6'd1;
          illegal_next = illegal_reg | beat_illegal;
        end
        if ((accept && last_beat) ||
            (bus.i_flush && (accept || state_reg == ACCUM))) begin
          state_next = DONE;
        end else if (accept) begin
          state_next = ACCUM;
        end
      end
      DONE: begin
        if (bus.i_blk_ready) begin
          state_next   = IDLE;
          acc_next     = 12'd0;
          cnt_next     = 6'd0;
          illegal_next = 1'b0;
        end
      end
      default: begin
        state_next   = IDLE;
        acc_next     = 12'd0;
        cnt_next     = 6'd0;
        illegal_next = 1'b0;
      end
    endcase
  end

  assign bus.o_ready          = (state_reg != DONE);
  assign bus.o_blk_valid      = (state_reg == DONE);
  assign bus.o_blk_len        = acc_reg;
  assign bus.o_incompressible = (32'(acc_reg) >= UNCOMP_BITS);
  assign bus.o_illegal        = illegal_reg;
  assign bus.o_beat_cnt       = cnt_reg;

endmodule

// File: tb/tb_length_accumulator.sv
// Self-checking bench: directed block scenarios plus random traffic compared
// every cycle against a queue-based model of the current block.
module tb_length_accumulator;

  localparam int BEATS       = 32;
  localparam int UNCOMP_BITS = 2048;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  length_accumulator_if bus ();

  length_accumulator #(.BEATS(BEATS), .UNCOMP_BITS(UNCOMP_BITS)) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: the block is the list of accepted code pairs; outputs derive from it.
  int m_q[$];
  bit m_pending;
  bit m_ok;

  function automatic int word_len(input int code);
    case (code)
      0: return 2;
      1: return 34;
      2: return 6;
      3: return 24;
      4: return 12;
      5: return 16;
      default: return 34;
    endcase
  endfunction

  function automatic int m_sum();
    int s = 0;
    foreach (m_q[k]) s += word_len(m_q[k] / 8) + word_len(m_q[k] % 8);
    return s;
  endfunction

  function automatic int m_ill();
    foreach (m_q[k]) if ((m_q[k] / 8) >= 6 || (m_q[k] % 8) >= 6) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete();
      m_pending = 0;
      m_ok = 1;
    end else if (m_ok) begin
      if (m_pending) begin
        if (bus.i_blk_ready) begin
          m_q.delete();
          m_pending = 0;
        end
      end else if (bus.i_valid) begin
        m_q.push_back(int'(bus.i_pat1) * 8 + int'(bus.i_pat2));
        if (m_q.size() == BEATS || bus.i_flush) m_pending = 1;
      end else if (bus.i_flush && m_q.size() > 0) begin
        m_pending = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cmp_blk_valid", 32'(bus.o_blk_valid), 32'(m_pending));
      check("cmp_ready", 32'(bus.o_ready), 32'(!m_pending));
      check("cmp_blk_len", 32'(bus.o_blk_len), 32'(m_sum()));
      check("cmp_illegal", 32'(bus.o_illegal), 32'(m_ill()));
      check("cmp_beat_cnt", 32'(bus.o_beat_cnt), 32'(m_q.size()));
      if (m_pending)
        check("cmp_incompressible", 32'(bus.o_incompressible), 32'(m_sum() >= UNCOMP_BITS));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_valid = 0; bus.i_flush = 0; bus.i_pat1 = 0; bus.i_pat2 = 0;
  endtask

  task automatic beats(input int n, input int p1, input int p2);
    for (int k = 0; k < n; k++) begin
      bus.i_valid = 1; bus.i_pat1 = 3'(p1); bus.i_pat2 = 3'(p2);
      step();
    end
    bus.i_valid = 0;
  endtask

  task automatic handshake();
    bus.i_blk_ready = 1;
    step();
    bus.i_blk_ready = 0;
  endtask

  initial begin
    logic [11:0] held_len;
    checks = 0;
    failures = 0;
    rst = 1;
    bus.i_blk_ready = 0;
    idle_inputs();
    step();
    step();
    rst = 0;
    check("reset_blk_valid", 32'(bus.o_blk_valid), 32'd0);
    check("reset_ready", 32'(bus.o_ready), 32'd1);
    check("reset_blk_len", 32'(bus.o_blk_len), 32'd0);
    check("reset_beat_cnt", 32'(bus.o_beat_cnt), 32'd0);

    // Flush alone in IDLE must not create a block
    bus.i_flush = 1; step(); bus.i_flush = 0;
    check("idle_flush_ignored", 32'(bus.o_blk_valid), 32'd0);

    beats(31, 0, 0);
    check("zero_31_not_done", 32'(bus.o_blk_valid), 32'd0);
    beats(1, 0, 0);
    check("zero_valid", 32'(bus.o_blk_valid), 32'd1);
    check("zero_len", 32'(bus.o_blk_len), 32'd128);
    check("zero_incomp", 32'(bus.o_incompressible), 32'd0);
    check("zero_cnt", 32'(bus.o_beat_cnt), 32'd32);
    handshake();

    beats(32, 1, 1);
    check("raw_len", 32'(bus.o_blk_len), 32'd2176);
    check("raw_incomp", 32'(bus.o_incompressible), 32'd1);
    handshake();

    beats(1, 2, 3);
    beats(1, 4, 5);
    bus.i_flush = 1;
    beats(1, 0, 1);
    bus.i_flush = 0;
    check("flush_valid", 32'(bus.o_blk_valid), 32'd1);
    check("flush_len", 32'(bus.o_blk_len), 32'd94);
    check("flush_cnt", 32'(bus.o_beat_cnt), 32'd3);
    handshake();

    beats(1, 6, 0);
    bus.i_flush = 1; step(); bus.i_flush = 0;
    check("illegal_flag", 32'(bus.o_illegal), 32'd1);
    check("illegal_len", 32'(bus.o_blk_len), 32'd36);
    handshake();
    beats(1, 0, 0);
    check("illegal_cleared", 32'(bus.o_illegal), 32'd0);

    // Stall in DONE with a beat offered: nothing accepted, result held
    bus.i_flush = 1; step(); bus.i_flush = 0;
    held_len = bus.o_blk_len;
    bus.i_valid = 1; bus.i_pat1 = 3'd1; bus.i_pat2 = 3'd1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_ready", 32'(bus.o_ready), 32'd0);
      check("stall_len", 32'(bus.o_blk_len), 32'(held_len));
    end
    handshake();
    bus.i_valid = 0;
    check("stall_release_len", 32'(bus.o_blk_len), 32'd0);
    check("stall_release_valid", 32'(bus.o_blk_valid), 32'd0);

    beats(10, 3, 3);
    rst = 1; step(); rst = 0;
    check("midreset_len", 32'(bus.o_blk_len), 32'd0);
    check("midreset_cnt", 32'(bus.o_beat_cnt), 32'd0);
    check("midreset_ready", 32'(bus.o_ready), 32'd1);
    beats(32, 2, 2);
    check("after_reset_len", 32'(bus.o_blk_len), 32'd384);
    check("after_reset_cnt", 32'(bus.o_beat_cnt), 32'd32);
    handshake();

    // Random traffic, checked by the per-cycle compare process
    for (int k = 0; k < 3000; k++) begin
      bus.i_valid     = ($urandom_range(0, 3) != 0);
      bus.i_pat1      = 3'($urandom_range(0, 7));
      bus.i_pat2      = 3'($urandom_range(0, 7));
      bus.i_flush     = ($urandom_range(0, 19) == 0);
      bus.i_blk_ready = ($urandom_range(0, 2) == 0);
      rst             = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 0;
    idle_inputs();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/length_accumulator.md
LENGTH_ACCUMULATOR -- requirements
Module: length_accumulator

Interface
REQ-001 SHALL have parameter BEATS, default 32, giving the beats per block (two words per beat).
REQ-002 SHALL have parameter UNCOMP_BITS, default 2048, giving the uncompressed block size in bits.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 i_clk  input  1  rising-edge clock.
REQ-005 i_reset  input  1  synchronous active-high reset.
REQ-006 i_valid  input  1  beat valid from the matching-length register stage.
REQ-007 o_ready  output  1  accumulator can accept a beat.
REQ-008 i_pat1  input  3  pattern code, word 1 of beat.
REQ-009 i_pat2  input  3  pattern code, word 2 of beat.
REQ-010 i_flush  input  1  close the current block early.
REQ-011 o_blk_valid  output  1  block result available.
REQ-012 i_blk_ready  input  1  consumer accepts the block result.
REQ-013 o_blk_len  output  12  total compressed bits of the block.
REQ-014 o_incompressible  output  1  o_blk_len >= UNCOMP_BITS.
REQ-015 o_illegal  output  1  an illegal pattern code was seen in the block.
REQ-016 o_beat_cnt  output  6  beats accepted in the current block.

Function
REQ-017 Code-to-length map per word SHALL be: 0 zzzz->2, 1 xxxx->34, 2 mmmm->6, 3 mmxx->24, 4 zzzx->12, 5 mmmx->16.
REQ-018 Codes 6 and 7 SHALL each count as 34 bits and set the block's sticky illegal flag.
REQ-019 A beat SHALL be accepted when i_valid && o_ready; its length is len(i_pat1)+len(i_pat2), in the range 4..68.
REQ-020 The FSM SHALL have exactly three states: IDLE, ACCUM, DONE.
REQ-021 o_ready SHALL be 1 in IDLE and ACCUM, and 0 in DONE.
REQ-022 IDLE: on an accepted beat -> ACCUM; the accumulator and o_beat_cnt take that beat's values on the next edge.
REQ-023 ACCUM: each accepted beat SHALL add its length to the accumulator and increment o_beat_cnt.
REQ-024 The transition to DONE SHALL occur at the edge after acceptance of beat number BEATS, or at any edge where i_flush=1 in ACCUM.
REQ-025 A beat accepted in the same cycle as i_flush SHALL be included in the block before DONE.
REQ-026 i_flush in IDLE with no valid beat SHALL be ignored; an empty block is never reported.
REQ-027 i_flush in IDLE with an accepted beat SHALL produce a one-beat block -> DONE.
REQ-028 DONE: o_blk_valid=1.
REQ-029 In DONE, o_blk_len, o_incompressible and o_illegal SHALL hold stable until the handshake.
REQ-030 DONE with i_blk_ready=1 -> IDLE at the next edge.
REQ-031 On leaving DONE, the accumulator, o_beat_cnt and the illegal flag SHALL clear.
REQ-032 In DONE, i_valid and i_flush SHALL be ignored (no acceptance).
REQ-033 Latency from acceptance of the final beat to o_blk_valid=1 SHALL be exactly 1 cycle.
REQ-034 o_blk_len SHALL be the accumulator; max 32*68=2176, so 12 bits never overflow.
REQ-035 o_incompressible SHALL be combinational from o_blk_len, and meaningful only when o_blk_valid=1.
REQ-036 o_beat_cnt SHALL count 0..BEATS and never wrap within a block.

Reset
REQ-037 i_reset=1 SHALL force the IDLE state, the accumulator to 0, o_beat_cnt to 0 and the illegal flag to 0 at the next edge.
REQ-038 Reset SHALL override any beat or handshake in the same cycle.
REQ-039 Immediately after reset, outputs SHALL be: o_blk_valid=0, o_ready=1, o_blk_len=0, o_incompressible=0, o_illegal=0, o_beat_cnt=0.
REQ-040 Reset mid-block (ACCUM or DONE) SHALL discard the partial or pending result with no o_blk_valid pulse.

Verification
REQ-041 32 beats of (0,0) -> o_blk_valid one cycle after the last beat; o_blk_len=128, o_incompressible=0, o_beat_cnt=32.
REQ-042 32 beats of (1,1) -> o_blk_len=2176, o_incompressible=1.
REQ-043 Beats (2,3), (4,5), then i_flush with beat (0,1) in the same cycle -> o_blk_len=94, o_beat_cnt=3, o_blk_valid next cycle.
REQ-044 Beat (6,0) then flush -> o_illegal=1, o_blk_len=36.
REQ-045 The next block SHALL start with o_illegal=0.
REQ-046 Hold i_blk_ready=0 for 5 cycles in DONE with i_valid=1 -> o_ready=0 and outputs stable; the handshake then returns to IDLE with o_blk_len=0.
REQ-047 Reset asserted after 10 beats -> next cycle all outputs at reset values; a following full block reports only its own 32 beats.
